// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the iterative 32-bit divider (start/annul/operand handshake, HI/LO write).
// Latency: request -> hilo_we_o = divider latency + 2 cycles; with DIV_ZERO_FAST_EN a divide-by-zero writes 1 cycle after the request.
// Backpressure: stall_o is high from the request cycle through BUSY; a flush aborts the divide and drains with annul.
// Optional feature macro: DIV_ZERO_FAST_EN (short-circuit divide-by-zero without starting the divider).
module div_ctrl #(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic        flush_i,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        stall_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   state_t        r_state;
   logic [CW-1:0] r_drain_cnt;
   logic          w_accept;
   logic          w_zero_fast;

   // A request is only taken from IDLE and never in a flush cycle.
   assign w_accept = (r_state == S_IDLE) && div_req_i && !flush_i;

`ifdef DIV_ZERO_FAST_EN
   assign w_zero_fast = (op2_i == 32'd0);
`else
   assign w_zero_fast = 1'b0;
`endif

   // Stall is combinational so EX freezes in the very cycle the request is seen.
   always_comb begin
      stall_o = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE:  stall_o = w_accept;
            S_BUSY:  stall_o = !flush_i;   // a flush releases the pipeline immediately
            S_DRAIN: stall_o = div_req_i;  // a post-flush request waits out the drain
            default: stall_o = 1'b0;       // DONE lets EX advance with the write
         endcase
      end
   end

   // Sequencer: state, drain counter and all registered divider/HI-LO outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_drain_cnt  <= '0;
         div_start_o  <= 1'b0;
         div_annul_o  <= 1'b0;
         div_signed_o <= 1'b0;
         div_op1_o    <= 32'd0;
         div_op2_o    <= 32'd0;
         hilo_we_o    <= 1'b0;
         hi_o         <= 32'd0;
         lo_o         <= 32'd0;
      end else begin
         hilo_we_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  div_op1_o    <= op1_i;
                  div_op2_o    <= op2_i;
                  div_signed_o <= div_signed_i;
                  if (w_zero_fast) begin
                     // Divider is never started; remainder is the dividend, quotient all ones.
                     hi_o      <= op1_i;
                     lo_o      <= 32'hFFFF_FFFF;
                     hilo_we_o <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     div_start_o <= 1'b1;
                     r_state     <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (flush_i) begin
                  // Flush wins over a coincident ready: drop the result, annul the divider.
                  div_start_o <= 1'b0;
                  div_annul_o <= 1'b1;
                  r_drain_cnt <= CW'(DRAIN_CYCLES - 1);
                  r_state     <= S_DRAIN;
               end else if (div_ready_i) begin
                  hi_o        <= div_result_i[63:32];
                  lo_o        <= div_result_i[31:0];
                  hilo_we_o   <= 1'b1;
                  div_start_o <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  div_annul_o <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_drain_cnt <= r_drain_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against an arithmetic reference model.
// A behavioural divider with programmable latency answers the start handshake.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_div_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        div_req_i;
   logic        div_signed_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic        flush_i;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        stall_o;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;
   int div_lat = 5;
   int n_ops = 0;
   int annul_cnt = 0;
   int we_cnt = 0;
   int start_low_run = 0;
   int last_gap = 0;

   div_ctrl #(.DRAIN_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
      .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i),
      .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Divider arithmetic: {remainder, quotient}, truncating toward zero; divide-by-zero gives 0.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [63:0] exp_hilo(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
`endif
      return ref_div(sgn, a, b);
   endfunction

   function automatic int exp_lat(input logic [31:0] b, input int lat);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 1;
`endif
      return lat + 2;
   endfunction

   // Event counters on registered outputs.
   always @(negedge clk) begin
      if (div_annul_o) annul_cnt++;
      if (hilo_we_o) we_cnt++;
      if (div_start_o) begin
         if (start_low_run > 0) last_gap = start_low_run;
         start_low_run = 0;
      end else begin
         start_low_run++;
      end
   end

   // Behavioural divider: ready div_lat cycles after start is first seen, held while start stays high.
   initial begin
      logic [64:0] snap;
      int dcnt;
      div_ready_i = 1'b0;
      div_result_i = 64'd0;
      dcnt = 0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (div_start_o !== 1'b1 || div_annul_o === 1'b1) begin
            dcnt = 0;
            div_ready_i = 1'b0;
            div_result_i = 64'd0;
         end else begin
            if (dcnt == 0) snap = {div_signed_o, div_op1_o, div_op2_o};
            else chk("op_hold", {7'd0, div_signed_o, div_op1_o, div_op2_o}, {7'd0, snap});
            dcnt++;
            if (dcnt > div_lat) begin
               div_ready_i = 1'b1;
               div_result_i = ref_div(div_signed_o, div_op1_o, div_op2_o);
            end
         end
      end
   end

   // One divide: request at a falling edge, wait (bounded) for the write strobe.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int extra);
      logic [63:0] e;
      int k;
      bit seen;
      e = exp_hilo(sgn, a, b);
      @(negedge clk);
      div_lat = lat;
      div_req_i = 1'b1;
      div_signed_i = sgn;
      op1_i = a;
      op2_i = b;
      n_ops++;
      #1 chk({tag, "_stall_req"}, stall_o, 1);
      seen = 0;
      k = 0;
      while (!seen && k < 300) begin
         @(negedge clk);
         k++;
         #1;
         if (hilo_we_o) begin
            seen = 1;
            chk({tag, "_hilo"}, {hi_o, lo_o}, e);
            chk({tag, "_stall_we"}, stall_o, 0);
            chk({tag, "_start_we"}, div_start_o, 0);
            chk({tag, "_lat"}, k, exp_lat(b, lat) + extra);
            div_req_i = 1'b0;
         end else begin
            chk({tag, "_stall_busy"}, stall_o, 1);
         end
      end
      chk({tag, "_we_seen"}, seen, 1);
      if (!seen) div_req_i = 1'b0;
   endtask

   initial begin
      int w0, a0;
      rst = 1'b1;
      div_req_i = 1'b0;
      div_signed_i = 1'b0;
      op1_i = 32'd0;
      op2_i = 32'd0;
      flush_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ctl", {div_start_o, div_annul_o, hilo_we_o, stall_o, div_signed_o}, 0);
      chk("rst_hilo", {hi_o, lo_o}, 0);
      chk("rst_ops", {div_op1_o, div_op2_o}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 8, 0);
      chk("divu_100_7_const", {hi_o, lo_o}, {32'd2, 32'd14});
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 12, 0);
      chk("div_m7_2_const", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // Flush 10 cycles after start, then a request that has to wait out the drain.
      w0 = we_cnt;
      a0 = annul_cnt;
      @(negedge clk);
      div_lat = 30;
      div_req_i = 1'b1;
      div_signed_i = 1'b0;
      op1_i = 32'd1000;
      op2_i = 32'd3;
      repeat (11) @(negedge clk);
      flush_i = 1'b1;
      div_req_i = 1'b0;
      #1 chk("flush_stall", stall_o, 0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("flush_annul", div_annul_o, 1);
      chk("flush_start", div_start_o, 0);
      run_div("post_flush", 1'b0, 32'd9, 32'd3, 4, 1);
      chk("post_flush_const", {hi_o, lo_o}, {32'd0, 32'd3});
      chk("flush_annul_cycles", annul_cnt - a0, 2);
      chk("flush_writes", we_cnt - w0, 1);

      // Back-to-back.
      w0 = we_cnt;
      run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 6, 0);
      chk("b2b_20_6_const", {hi_o, lo_o}, {32'd2, 32'd3});
      run_div("b2b_7_7", 1'b0, 32'd7, 32'd7, 3, 0);
      chk("b2b_7_7_const", {hi_o, lo_o}, {32'd0, 32'd1});
      chk("b2b_gap", last_gap, 2);
      chk("b2b_writes", we_cnt - w0, 2);

      // Reset in the middle of BUSY.
      @(negedge clk);
      div_lat = 40;
      div_req_i = 1'b1;
      div_signed_i = 1'b1;
      op1_i = 32'hFFFF_FF9C;
      op2_i = 32'd7;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      div_req_i = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rst_ctl", {div_start_o, div_annul_o, hilo_we_o, stall_o, div_signed_o}, 0);
      chk("mid_rst_hilo", {hi_o, lo_o}, 0);
      chk("mid_rst_ops", {div_op1_o, div_op2_o}, 0);
      rst = 1'b0;
      run_div("post_rst", 1'b0, 32'd15, 32'd4, 6, 0);
      chk("post_rst_const", {hi_o, lo_o}, {32'd3, 32'd3});

      // Divide by zero.
      run_div("zero", 1'b1, 32'h1234, 32'd0, 20, 0);
`ifdef DIV_ZERO_FAST_EN
      chk("zero_const", {hi_o, lo_o}, {32'h1234, 32'hFFFF_FFFF});
`else
      chk("zero_const", {hi_o, lo_o}, 64'd0);
`endif

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic s;
         int l;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'd0 - 32'($urandom_range(1, 15));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         l = $urandom_range(1, 40);
         run_div("rnd", s, a, b, l, 0);
      end

      @(negedge clk);
      #1 chk("total_writes", we_cnt, n_ops);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
